// File: rtl/regwb_sched.sv
// Writeback scheduler for the dual-port register memory: one FIFO per issue
// lane, heads drive the write ports, same-register heads are serialized by age.

module regwb_lane #(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int SEQW  = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic [4:0]      push_reg,
  input  logic [DW-1:0]   push_data,
  input  logic [SEQW-1:0] push_seq,
  input  logic            pop,
  output logic            ready,
  output logic            head_vld,
  output logic [4:0]      head_reg,
  output logic [DW-1:0]   head_data,
  output logic [SEQW-1:0] head_seq,
  output logic [31:0]     busy
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][4:0]      reg_q;
  logic [DEPTH-1:0][DW-1:0]   data_q;
  logic [DEPTH-1:0][SEQW-1:0] seq_q;
  logic [DEPTH-1:0]           vld_q, push_m, pop_m;
  logic [PW-1:0]              rd_ptr, wr_ptr;
  logic [PW:0]                cnt_q;

  assign ready     = (cnt_q != (PW+1)'(DEPTH));
  assign head_vld  = |cnt_q;
  assign head_reg  = reg_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign head_seq  = seq_q[rd_ptr];
  assign push_m    = push ? (DEPTH'(1) << wr_ptr) : '0;
  assign pop_m     = pop  ? (DEPTH'(1) << rd_ptr) : '0;

  // Per-entry valid bits exist only to build the busy vector.
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i]) busy[reg_q[i]] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_q  <= '0;
      data_q <= '0;
      seq_q  <= '0;
      vld_q  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        reg_q[wr_ptr]  <= push_reg;
        data_q[wr_ptr] <= push_data;
        seq_q[wr_ptr]  <= push_seq;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      vld_q <= (vld_q & ~pop_m) | push_m;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module regwb_sched #(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int SEQW  = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in0_valid,
  output logic          in0_ready,
  input  logic [4:0]    in0_reg,
  input  logic [DW-1:0] in0_data,
  input  logic          in1_valid,
  output logic          in1_ready,
  input  logic [4:0]    in1_reg,
  input  logic [DW-1:0] in1_data,
  output logic          regwrite,
  output logic [4:0]    wrreg,
  output logic [DW-1:0] wrdata,
  output logic          regwrite1,
  output logic [4:0]    wrreg1,
  output logic [DW-1:0] wrdata1,
  output logic [31:0]   busy,
  output logic          idle
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]                 vin, rdy, push, pop, hv;
  logic [NUM_LANES-1:0][4:0]            preg, hreg;
  logic [NUM_LANES-1:0][DW-1:0]         pdata, hdata;
  logic [NUM_LANES-1:0][SEQW-1:0]       hseq;
  logic [NUM_LANES-1:0][31:0]           lbusy;
  logic [SEQW-1:0]                      seq_q, age;
  logic                                 same, older0;

  assign vin   = {in1_valid, in0_valid};
  assign preg  = {in1_reg, in0_reg};
  assign pdata = {in1_data, in0_data};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    // r0 writes are accepted but swallowed here.
    assign push[l] = vin[l] & rdy[l] & (|preg[l]);
    regwb_lane #(.DW(DW), .DEPTH(DEPTH), .SEQW(SEQW)) u_lane (
      .clk(clk), .reset_n(reset_n),
      .push(push[l]), .push_reg(preg[l]), .push_data(pdata[l]), .push_seq(seq_q),
      .pop(pop[l]), .ready(rdy[l]),
      .head_vld(hv[l]), .head_reg(hreg[l]), .head_data(hdata[l]), .head_seq(hseq[l]),
      .busy(lbusy[l])
    );
  end

  // Wrapped age compare: lane 0 is older when seq0 - seq1 <= 0 as signed.
  assign age    = hseq[0] - hseq[1];
  assign older0 = age[SEQW-1] | ~(|age);
  assign same   = hv[0] & hv[1] & (hreg[0] == hreg[1]);
  assign pop[0] = hv[0] & (~same | older0);
  assign pop[1] = hv[1] & (~same | ~older0);

  assign regwrite  = pop[0];
  assign wrreg     = pop[0] ? hreg[0]  : '0;
  assign wrdata    = pop[0] ? hdata[0] : '0;
  assign regwrite1 = pop[1];
  assign wrreg1    = pop[1] ? hreg[1]  : '0;
  assign wrdata1   = pop[1] ? hdata[1] : '0;

  assign in0_ready = rdy[0];
  assign in1_ready = rdy[1];
  assign busy      = lbusy[0] | lbusy[1];
  assign idle      = ~hv[0] & ~hv[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   seq_q <= '0;
    else if (|push) seq_q <= seq_q + 1'b1;
  end
endmodule

// File: tb/tb_regwb_sched.sv
// Directed bench for regwb_sched: stimulus queues expected port writes, a
// negedge monitor pops and compares them and keeps a shadow register file.

module tb_regwb_sched;
  localparam int DW = 32;

  logic          clk = 1'b0, reset_n;
  logic          in0_valid, in0_ready, in1_valid, in1_ready;
  logic [4:0]    in0_reg, in1_reg, wrreg, wrreg1;
  logic [DW-1:0] in0_data, in1_data, wrdata, wrdata1;
  logic          regwrite, regwrite1, idle;
  logic [31:0]   busy;

  int checks = 0, errors = 0;
  bit nack0 = 1'b0;
  logic [36:0]   q0[$], q1[$];
  logic [DW-1:0] shadow[32];

  regwb_sched #(.DW(DW), .DEPTH(2), .SEQW(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_reg(in0_reg), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_reg(in1_reg), .in1_data(in1_data),
    .regwrite(regwrite), .wrreg(wrreg), .wrdata(wrdata),
    .regwrite1(regwrite1), .wrreg1(wrreg1), .wrdata1(wrdata1),
    .busy(busy), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every presented write must match the head of its lane's queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (regwrite) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL port0_unexpected: got r%0d=%0h expected no write", wrreg, wrdata);
        end else chk("port0_write", {27'd0, wrreg, wrdata}, {27'd0, q0.pop_front()});
        shadow[wrreg] = wrdata;
      end
      if (regwrite1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL port1_unexpected: got r%0d=%0h expected no write", wrreg1, wrdata1);
        end else chk("port1_write", {27'd0, wrreg1, wrdata1}, {27'd0, q1.pop_front()});
        shadow[wrreg1] = wrdata1;
      end
      if (regwrite && regwrite1) chk("dual_distinct_reg", 64'(wrreg == wrreg1), 64'd0);
    end
  end

  // Called at a negedge; the following posedge samples the inputs.
  task automatic step(input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] r1, input logic [31:0] d1);
    in0_valid = v0; in0_reg = r0; in0_data = d0;
    in1_valid = v1; in1_reg = r1; in1_data = d1;
    if (v0 && r0 != 5'd0 && !nack0) q0.push_back({r0, d0});
    if (v1 && r1 != 5'd0) q1.push_back({r1, d1});
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    reset_n = 1'b0;
    in0_valid = 1'b0; in0_reg = '0; in0_data = '0;
    in1_valid = 1'b0; in1_reg = '0; in1_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_regwrite", regwrite, 1'b0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_ready", {in1_ready, in0_ready}, 2'b11);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_seq", dut.seq_q, 3'd0);

    // Independent dual write
    step(1'b1, 5'd8, 32'hAAAA0001, 1'b1, 5'd9, 32'hBBBB0002);
    chk("dual_we", {regwrite, regwrite1}, 2'b11);
    chk("dual_regs", {wrreg, wrreg1}, {5'd8, 5'd9});
    chk("dual_busy_on", busy, 32'h0000_0300);
    chk("dual_not_idle", idle, 1'b0);
    idle_step();
    chk("dual_busy_off", busy, 32'h0);
    chk("dual_idle", idle, 1'b1);
    chk("dual_seq", dut.seq_q, 3'd1);

    // Same-cycle conflict on r10: lane 0 wins the tie
    step(1'b1, 5'd10, 32'h1, 1'b1, 5'd10, 32'h2);
    chk("cfl_c1_we", {regwrite, regwrite1}, 2'b10);
    chk("cfl_c1_data", wrdata, 32'h1);
    chk("cfl_c1_busy", busy, 32'h0000_0400);
    idle_step();
    chk("cfl_c2_we", {regwrite, regwrite1}, 2'b01);
    chk("cfl_c2_data", wrdata1, 32'h2);
    chk("cfl_c2_busy", busy, 32'h0000_0400);
    idle_step();
    chk("cfl_busy_clear", busy, 32'h0);
    chk("cfl_final_r10", shadow[10], 32'h2);

    // Cross-cycle age: lane 1 stalled behind r3, then r12 meets at the heads
    step(1'b1, 5'd3, 32'h31, 1'b1, 5'd3, 32'h32);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h5);
    step(1'b1, 5'd12, 32'h7, 1'b0, 5'd0, 32'h0);
    chk("age_c1_we", {regwrite, regwrite1}, 2'b01);
    chk("age_c1_data", wrdata1, 32'h5);
    idle_step();
    chk("age_c2_we", {regwrite, regwrite1}, 2'b10);
    chk("age_c2_data", wrdata, 32'h7);
    idle_step();
    chk("age_final_r12", shadow[12], 32'h7);
    chk("age_final_r3", shadow[3], 32'h32);
    chk("age_seq", dut.seq_q, 3'd5);

    // Register 0 drop
    step(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    chk("r0_regwrite", regwrite, 1'b0);
    chk("r0_busy", busy, 32'h0);
    chk("r0_idle", idle, 1'b1);
    chk("r0_seq", dut.seq_q, 3'd5);
    step(1'b1, 5'd1, 32'h1234, 1'b0, 5'd0, 32'h0);
    chk("r0_after_write", {regwrite, wrreg}, {1'b1, 5'd1});
    idle_step();
    chk("r0_after_seq", dut.seq_q, 3'd6);

    // Backpressure; lane 1's r20 gets seq 7, lane 0's r20 gets seq 0 (wrap)
    step(1'b1, 5'd3, 32'h41, 1'b1, 5'd3, 32'h42);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'hB20);
    chk("bp_in1_full", in1_ready, 1'b0);
    step(1'b1, 5'd20, 32'hA20, 1'b0, 5'd0, 32'h0);
    chk("bp_wrap_order", {regwrite, regwrite1}, 2'b01);
    chk("bp_seq_wrapped", dut.seq_q, 3'd1);
    step(1'b1, 5'd21, 32'hA21, 1'b0, 5'd0, 32'h0);
    chk("bp_in0_full", in0_ready, 1'b0);
    chk("bp_busy", busy, 32'h0030_0000);
    nack0 = 1'b1;
    step(1'b1, 5'd22, 32'hA22, 1'b0, 5'd0, 32'h0);
    nack0 = 1'b0;
    chk("bp_in0_reopen", in0_ready, 1'b1);
    step(1'b1, 5'd22, 32'hA22, 1'b0, 5'd0, 32'h0);
    step(1'b1, 5'd23, 32'hA23, 1'b0, 5'd0, 32'h0);
    idle_step();
    idle_step();
    chk("bp_r20", shadow[20], 32'hA20);
    chk("bp_r21", shadow[21], 32'hA21);
    chk("bp_r22", shadow[22], 32'hA22);
    chk("bp_r23", shadow[23], 32'hA23);
    chk("bp_r3", shadow[3], 32'h42);
    chk("bp_seq", dut.seq_q, 3'd4);
    chk("bp_q0_drained", 64'(q0.size()), 64'd0);
    chk("bp_q1_drained", 64'(q1.size()), 64'd0);

    // Reset mid-drain with lane 0 full of r5/r6
    step(1'b1, 5'd3, 32'h51, 1'b1, 5'd3, 32'h52);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h99);
    step(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
    chk("rmd_hold", {regwrite, regwrite1}, 2'b01);
    in0_valid = 1'b1; in0_reg = 5'd6; in0_data = 32'h22;
    @(posedge clk);
    #1;
    in0_valid = 1'b0;
    chk("rmd_full", in0_ready, 1'b0);
    chk("rmd_driving", regwrite, 1'b1);
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("rmd_ports", {regwrite, regwrite1, wrreg, wrreg1}, 12'h0);
    chk("rmd_data", {wrdata, wrdata1}, 64'h0);
    chk("rmd_busy", busy, 32'h0);
    chk("rmd_idle", idle, 1'b1);
    chk("rmd_ready", {in1_ready, in0_ready}, 2'b11);
    chk("rmd_seq", dut.seq_q, 3'd0);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    repeat (3) idle_step();
    chk("rmd_r5", shadow[5], 32'h99);
    chk("rmd_r6", shadow[6], 32'h0);
    chk("rmd_idle_after", idle, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regwb_sched.md
Name: regwb_sched

Overview:
- Writeback scheduler for the dual-issue register memory's two write ports (regwrite/wrreg/wrdata and regwrite1/wrreg1/wrdata1).
- Accepts writeback requests from pipeline lane 0 and lane 1 through valid/ready handshakes and buffers them in a per-lane FIFO.
- Drives both write ports every cycle and serializes same-register conflicts so the younger write always lands last.
- Exports a pending-write busy vector that issue logic uses for hazard checks.

Parameters:
- DW, 32, write data width.
- DEPTH, 2, entries per lane FIFO (power of two, 2..4).
- SEQW, 3, age-stamp width; must satisfy 2^SEQW > 2*DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in0_valid  in  1  lane 0 writeback request.
- in0_ready  out  1  lane 0 FIFO can accept.
- in0_reg  in  5  lane 0 destination register.
- in0_data  in  DW  lane 0 write data.
- in1_valid  in  1  lane 1 writeback request.
- in1_ready  out  1  lane 1 FIFO can accept.
- in1_reg  in  5  lane 1 destination register.
- in1_data  in  DW  lane 1 write data.
- regwrite  out  1  write port 0 enable.
- wrreg  out  5  write port 0 register.
- wrdata  out  DW  write port 0 data.
- regwrite1  out  1  write port 1 enable.
- wrreg1  out  5  write port 1 register.
- wrdata1  out  DW  write port 1 data.
- busy  out  32  busy[r]=1 while any buffered entry targets register r.
- idle  out  1  both FIFOs empty.

Behaviour:
- Reset, asserted asynchronously at any time, including mid-drain:
  - both FIFOs empty, buffered requests discarded, seq counter = 0;
  - regwrite = regwrite1 = 0, wrreg/wrdata = 0, busy = 0, idle = 1, in0_ready = in1_ready = 1.
- Accept:
  - inX accepted when inX_valid && inX_ready at the clock edge.
  - inX_ready = (lane X count < DEPTH), driven from registered count only; a same-cycle pop does not raise ready.
- Register 0:
  - an accepted request with reg 0 is consumed and dropped;
  - it is never enqueued, never sets busy, and never drives a port.
- Age stamp:
  - each enqueued entry stores seq, the value of the counter at its accept edge;
  - seq increments by 1 (mod 2^SEQW) on any edge where at least one non-zero request is accepted;
  - when both lanes are accepted on the same edge with equal seq, lane 0 is older.
- Port mapping: lane 0 head drives port 0 and lane 1 head drives port 1. Output mux logic is combinational from the FIFO heads.
- Issue rule, per cycle:
  - Only one head valid: that head writes.
  - Both heads valid, different registers: both write; both pop at the edge.
  - Both heads valid, same register: only the older head writes and pops; the younger head holds to the next cycle.
  - Older is decided by (seqA - seqB) mod 2^SEQW interpreted as signed; on equal seq, lane 0 is older.
- Latency: a request accepted at edge N is visible on its port during cycle N+1 at the earliest and is written to the register memory at edge N+1.
- Simultaneous push and pop on the same lane: allowed. Count is unchanged and FIFO order is preserved.
- FIFO wrap: read and write pointers wrap modulo DEPTH; the full and empty flags come from the count.
- busy:
  - combinational OR over all valid FIFO entries;
  - clears in the cycle after the last entry for that register pops;
  - not set by an in-flight (not yet accepted) request.
- idle = (count0 == 0) && (count1 == 0).
- The regm same-register read bypass covers the write cycle; busy covers every earlier cycle.

Test Plan:
- Reset mid-drain:
  - fill lane 0 with r5=0x11, r6=0x22, then pulse reset_n low for 3 ns between edges;
  - outputs 0 immediately, busy=0, idle=1, and neither write occurs after release.
- Independent dual write:
  - in0 r8=0xAAAA0001 and in1 r9=0xBBBB0002 accepted on the same edge;
  - next cycle regwrite=regwrite1=1, wrreg=8, wrreg1=9; busy[8] and busy[9] are high for exactly 1 cycle.
- Same-cycle conflict:
  - in0 r10=0x1 and in1 r10=0x2 on the same edge;
  - cycle 1: port 0 writes 0x1, regwrite1=0;
  - cycle 2: port 1 writes 0x2, so final r10=0x2 and busy[10] clears after cycle 2.
- Cross-cycle age ordering:
  - in1 r12=0x5 at edge N, then in0 r12=0x7 at edge N+1, while lane 1 is stalled behind an r3 conflict;
  - the lane 1 entry (0x5) writes first and 0x7 last.
- Full backpressure:
  - hold in0_valid with 4 distinct registers while lane 1 blocks lane 0 heads via conflicts;
  - in0_ready drops after DEPTH entries and no request is lost or duplicated;
  - the seq counter wraps past 7 with ordering still correct.
- Register 0 drop:
  - in0 r0=0xDEAD accepted;
  - regwrite stays 0, busy stays 0, and the seq counter is unchanged.
